// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MEM_BYTES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // A word access is legal only when aligned and fully inside the RAM.
  function automatic logic addr_bad(input logic [DATA_W-1:0] addr,
                                    input logic [DATA_W-1:0] mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > (mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on contention the port not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_b,
  output logic [1:0] gnt
);

  // One-hot grant; bit 0 is port A, bit 1 is port B.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_b ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a negedge-acting single-port RAM.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_done,
  output logic              b_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              a_err,
  output logic              b_err,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [DATA_W-1:0] MEM_BYTES_W = DATA_W'(MEM_BYTES);

  state_t            state;
  logic              last_b;
  logic              win_b;
  logic              acc_we;
  logic              acc_err;
  logic [1:0]        pick;
  logic              sel_we;
  logic              sel_err;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req    ({b_req, a_req}),
    .last_b (last_b),
    .gnt    (pick)
  );

  // Request fields of whichever port the picker selected.
  always_comb begin
    if (pick[1]) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end else begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end
    sel_err = addr_bad(sel_addr, MEM_BYTES_W);
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      win_b     <= 1'b0;
      acc_we    <= 1'b0;
      acc_err   <= 1'b0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_err     <= 1'b0;
      b_err     <= 1'b0;
      a_rdata   <= {DATA_W{1'b0}};
      b_rdata   <= {DATA_W{1'b0}};
      ram_rw    <= 1'b0;
      ram_addr  <= {DATA_W{1'b0}};
      ram_wdata <= {DATA_W{1'b0}};
    end else begin
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      a_err  <= 1'b0;
      b_err  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          ram_rw <= 1'b0;
          if (pick != 2'b00) begin
            state     <= ACCESS;
            a_gnt     <= pick[0];
            b_gnt     <= pick[1];
            last_b    <= pick[1];
            win_b     <= pick[1];
            acc_we    <= sel_we;
            acc_err   <= sel_err;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            // A rejected access must never reach the RAM as a write.
            ram_rw    <= sel_we & ~sel_err;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state  <= RESP;
          ram_rw <= 1'b0;
          if (win_b) begin
            b_done <= 1'b1;
            b_err  <= acc_err;
            if (acc_err) begin
              b_rdata <= {DATA_W{1'b0}};
            end else if (!acc_we) begin
              b_rdata <= ram_rdata;
            end
          end else begin
            a_done <= 1'b1;
            a_err  <= acc_err;
            if (acc_err) begin
              a_rdata <= {DATA_W{1'b0}};
            end else if (!acc_we) begin
              a_rdata <= ram_rdata;
            end
          end
        end
        default: begin
          state  <= IDLE;
          ram_rw <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: negedge RAM model plus a word-array/round-robin reference model.
module tb_mem_arbiter;

  localparam int MEM_BYTES = 64;
  localparam int WORDS     = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req, a_we, b_we;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_done, b_done, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_rw;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .a_err(a_err), .b_err(b_err),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM acting on the falling edge.
  logic [31:0] ram [WORDS] = '{default: 32'h0};
  int          ram_writes  = 0;
  always @(negedge clk) begin
    if (ram_rw) begin
      if (ram_addr < 32'(MEM_BYTES)) ram[ram_addr[5:2]] = ram_wdata;
      ram_writes++;
    end
    ram_rdata = (ram_addr < 32'(MEM_BYTES)) ? ram[ram_addr[5:2]] : 32'hBAD0_BAD0;
  end

  // Reference model state.
  logic [31:0] mdl_mem [WORDS] = '{default: 32'h0};
  logic [31:0] mdl_rdata [2];
  bit          mdl_last_b;

  function automatic bit mdl_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr > MEM_BYTES - 4);
  endfunction

  task automatic mdl_apply(input bit pb, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output bit err_e, output logic [31:0] rd_e);
    err_e = mdl_err(addr);
    if (err_e) mdl_rdata[pb] = 32'h0;
    else if (we) mdl_mem[addr / 4] = wd;
    else mdl_rdata[pb] = mdl_mem[addr / 4];
    rd_e = mdl_rdata[pb];
    mdl_last_b = pb;
  endtask

  task automatic set_port(input bit pb, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wd);
    if (pb) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    end
  endtask

  function automatic logic [31:0] rand_addr(input int words);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, words - 1) * 4);
    else if (r == 7) return 32'($urandom_range(0, words - 1) * 4 + $urandom_range(1, 3));
    else return 32'(MEM_BYTES + $urandom_range(0, 3) * 4);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    mdl_rdata[0] = 32'h0;
    mdl_rdata[1] = 32'h0;
    mdl_last_b   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives one request on one port and records what the DUT returns.
  task automatic access(input bit pb, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output int gnt_cyc, output int done_cyc, output bit err_o,
                        output logic [31:0] rd_o, output int rw_cyc);
    gnt_cyc = -1; done_cyc = -1; err_o = 1'b0; rd_o = 32'h0; rw_cyc = 0;
    set_port(pb, 1'b1, we, addr, wd);
    for (int c = 1; c <= 6 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (ram_rw) rw_cyc++;
      if ((pb ? b_gnt : a_gnt) && gnt_cyc < 0) begin
        gnt_cyc = c;
        set_port(pb, 1'b0, we, addr, wd);
      end
      if (pb ? b_done : a_done) begin
        done_cyc = c;
        err_o    = pb ? b_err : a_err;
        rd_o     = pb ? b_rdata : a_rdata;
      end
    end
    set_port(pb, 1'b0, we, addr, wd);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_gnt, b_gnt, a_done, b_done, a_err, b_err, a_rdata, b_rdata,
         ram_rw, ram_addr, ram_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b%b done=%b%b err=%b%b rw=%b addr=%h, required all zero",
               a_gnt, b_gnt, a_done, b_done, a_err, b_err, ram_rw, ram_addr);
    end
    do_reset();
  endtask

  task automatic test_single_access(input string tag, input bit pb, input bit we,
                                    input logic [31:0] addr, input logic [31:0] wd);
    int gc, dc, rwc;
    bit eo, ee;
    logic [31:0] ro, re;
    access(pb, we, addr, wd, gc, dc, eo, ro, rwc);
    mdl_apply(pb, we, addr, wd, ee, re);
    checks++;
    if (gc !== 1) begin
      failures++; $display("FAIL %s_gnt_cycle: got %0d required 1", tag, gc);
    end
    checks++;
    if (dc !== 2) begin
      failures++; $display("FAIL %s_done_cycle: got %0d required 2", tag, dc);
    end
    checks++;
    if (eo !== ee) begin
      failures++; $display("FAIL %s_err: got %b required %b", tag, eo, ee);
    end
    checks++;
    if (ro !== re) begin
      failures++; $display("FAIL %s_rdata: got %h required %h", tag, ro, re);
    end
    checks++;
    if (rwc != ((we && !ee) ? 1 : 0)) begin
      failures++; $display("FAIL %s_ram_rw_cycles: got %0d required %0d", tag, rwc, (we && !ee) ? 1 : 0);
    end
    checks++;
    if ((pb ? a_rdata : b_rdata) !== mdl_rdata[!pb]) begin
      failures++;
      $display("FAIL %s_other_rdata: got %h required %h", tag, pb ? a_rdata : b_rdata, mdl_rdata[!pb]);
    end
  endtask

  task automatic test_mem_compare(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== mdl_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL %s_mem: got %0d differing words required 0", tag, bad);
    end
  endtask

  // Both ports request together; each drops req on its own gnt.
  task automatic run_pair(input string tag, input bit wa, input logic [31:0] aa, input logic [31:0] da,
                          input bit wb, input logic [31:0] ab, input logic [31:0] db);
    bit          order [$];
    bit          da_seen, db_seen, ea, eb, ee, first_b;
    logic [31:0] ra, rb, re;
    logic [31:0] exp_rd [2];
    bit          exp_err [2];
    da_seen = 1'b0; db_seen = 1'b0; ea = 1'b0; eb = 1'b0; ra = 32'h0; rb = 32'h0;
    first_b = ~mdl_last_b;
    set_port(1'b0, 1'b1, wa, aa, da);
    set_port(1'b1, 1'b1, wb, ab, db);
    for (int c = 1; c <= 8 && !(da_seen && db_seen); c++) begin
      @(posedge clk); #1;
      if (a_gnt) begin order.push_back(1'b0); set_port(1'b0, 1'b0, wa, aa, da); end
      if (b_gnt) begin order.push_back(1'b1); set_port(1'b1, 1'b0, wb, ab, db); end
      if (a_done) begin da_seen = 1'b1; ea = a_err; ra = a_rdata; end
      if (b_done) begin db_seen = 1'b1; eb = b_err; rb = b_rdata; end
    end
    set_port(1'b0, 1'b0, wa, aa, da);
    set_port(1'b1, 1'b0, wb, ab, db);
    for (int k = 0; k < 2; k++) begin
      bit p;
      p = (k == 0) ? first_b : ~first_b;
      mdl_apply(p, p ? wb : wa, p ? ab : aa, p ? db : da, ee, re);
      exp_err[p] = ee;
      exp_rd[p]  = re;
    end
    checks++;
    if (order.size() != 2 || order[0] !== first_b) begin
      failures++;
      $display("FAIL %s_order: got %0d grants first=%0d required 2 grants first=%0d",
               tag, order.size(), (order.size() > 0) ? int'(order[0]) : -1, first_b);
    end
    checks++;
    if (!(da_seen && db_seen) || ea !== exp_err[0] || eb !== exp_err[1]) begin
      failures++;
      $display("FAIL %s_err: got done=%b%b err=%b%b required done=11 err=%b%b",
               tag, da_seen, db_seen, ea, eb, exp_err[0], exp_err[1]);
    end
    checks++;
    if (ra !== exp_rd[0] || rb !== exp_rd[1]) begin
      failures++;
      $display("FAIL %s_rdata: got a=%h b=%h required a=%h b=%h", tag, ra, rb, exp_rd[0], exp_rd[1]);
    end
  endtask

  task automatic test_write_read();
    test_single_access("wr_deadbeef", 1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF);
    test_single_access("rd_deadbeef", 1'b0, 1'b0, 32'd8, 32'h0);
    test_mem_compare("write_read");
  endtask

  task automatic test_contention();
    int  gcyc [$];
    bit  gwho [$];
    bit  last, w, ee;
    logic [31:0] re;
    do_reset();
    set_port(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
    for (int c = 1; c <= 12 && gcyc.size() < 4; c++) begin
      @(posedge clk); #1;
      if (a_gnt) begin gcyc.push_back(c); gwho.push_back(1'b0); end
      if (b_gnt) begin gcyc.push_back(c); gwho.push_back(1'b1); end
    end
    set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    last = mdl_last_b;
    checks++;
    if (gcyc.size() != 4) begin
      failures++; $display("FAIL contention_count: got %0d grants required 4", gcyc.size());
    end
    for (int i = 0; i < 4; i++) begin
      w = ~last;
      last = w;
      mdl_apply(w, 1'b0, w ? 32'd4 : 32'd0, 32'h0, ee, re);
      if (i < gcyc.size()) begin
        checks++;
        if (gwho[i] !== w || gcyc[i] != 1 + 2 * i) begin
          failures++;
          $display("FAIL contention_grant%0d: got port=%0d cycle=%0d required port=%0d cycle=%0d",
                   i, gwho[i], gcyc[i], w, 1 + 2 * i);
        end
      end
    end
    checks++;
    if (a_rdata !== mdl_rdata[0] || b_rdata !== mdl_rdata[1]) begin
      failures++;
      $display("FAIL contention_rdata: got a=%h b=%h required a=%h b=%h",
               a_rdata, b_rdata, mdl_rdata[0], mdl_rdata[1]);
    end
  endtask

  task automatic test_errors();
    int wr_before;
    wr_before = ram_writes;
    test_single_access("misaligned_b", 1'b1, 1'b0, 32'd6, 32'h0);
    test_single_access("out_of_range_a", 1'b0, 1'b1, 32'd64, 32'h5555_AAAA);
    checks++;
    if (ram_writes != wr_before) begin
      failures++; $display("FAIL error_no_write: got %0d RAM writes required 0", ram_writes - wr_before);
    end
    test_mem_compare("errors");
  endtask

  task automatic test_boundary();
    test_single_access("wr_addr60", 1'b0, 1'b1, 32'd60, 32'h1122_3344);
    test_single_access("rd_addr60", 1'b0, 1'b0, 32'd60, 32'h0);
    test_mem_compare("boundary");
  endtask

  task automatic test_reset_in_access();
    int wr_before;
    bit dn;
    do_reset();
    wr_before = ram_writes;
    set_port(1'b0, 1'b1, 1'b1, 32'd4, 32'hCAFE_0004);
    @(posedge clk); #1;
    checks++;
    if (a_gnt !== 1'b1 || ram_rw !== 1'b1) begin
      failures++; $display("FAIL rst_access_start: got gnt=%b rw=%b required 1 1", a_gnt, ram_rw);
    end
    set_port(1'b0, 1'b0, 1'b1, 32'd4, 32'hCAFE_0004);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_gnt, b_gnt, a_done, b_done, a_err, b_err, a_rdata, b_rdata,
         ram_rw, ram_addr, ram_wdata} !== '0) begin
      failures++;
      $display("FAIL rst_access_outputs: got rw=%b addr=%h wdata=%h gnt=%b required all zero",
               ram_rw, ram_addr, ram_wdata, a_gnt);
    end
    mdl_rdata[0] = 32'h0;
    mdl_rdata[1] = 32'h0;
    mdl_last_b   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (a_done || b_done) dn = 1'b1;
    end
    checks++;
    if (dn || ram_writes != wr_before) begin
      failures++;
      $display("FAIL rst_access_dropped: got done=%b writes=%0d required 0 0", dn, ram_writes - wr_before);
    end
    test_mem_compare("rst_access");
    run_pair("rst_next_pair", 1'b0, 32'd0, 32'h0, 1'b0, 32'd4, 32'h0);
  endtask

  task automatic test_random_singles(input int n);
    for (int i = 0; i < n; i++)
      test_single_access($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         rand_addr(WORDS), $urandom);
    test_mem_compare("random_singles");
  endtask

  task automatic test_random_pairs(input int n);
    for (int i = 0; i < n; i++)
      run_pair($sformatf("pair%0d", i),
               1'($urandom_range(0, 1)), rand_addr(4), $urandom,
               1'($urandom_range(0, 1)), rand_addr(4), $urandom);
    test_mem_compare("random_pairs");
  endtask

  initial begin
    rst_n = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    mdl_rdata[0] = 32'h0;
    mdl_rdata[1] = 32'h0;
    mdl_last_b   = 1'b1;
    test_reset();
    test_write_read();
    test_contention();
    test_errors();
    test_boundary();
    test_reset_in_access();
    test_random_singles(30);
    test_random_pairs(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64, meaning the RAM size in bytes (legal word addresses are 0..MEM_BYTES-4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge; the RAM it drives acts on negedge clk.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports a_req/b_req, input, 1 bit each: the port's request is pending.
REQ-005 SHALL have ports a_we/b_we, input, 1 bit each: 1 means write, 0 means read.
REQ-006 SHALL have ports a_addr/b_addr, input, 32 bits each: byte address.
REQ-007 SHALL have ports a_wdata/b_wdata, input, 32 bits each: write data.
REQ-008 SHALL have ports a_gnt/b_gnt, output, 1 bit each: one-cycle pulse meaning the request was accepted.
REQ-009 SHALL have ports a_done/b_done, output, 1 bit each: one-cycle pulse meaning the access completed.
REQ-010 SHALL have ports a_rdata/b_rdata, output, 32 bits each: read data, held until that port's next done.
REQ-011 SHALL have ports a_err/b_err, output, 1 bit each: valid with done; 1 means the access was rejected.
REQ-012 SHALL have port ram_rw, output, 1 bit: RAM write enable, 1 means write.
REQ-013 SHALL have ports ram_addr and ram_wdata, output, 32 bits each: RAM address and RAM write data.
REQ-014 SHALL have port ram_rdata, input, 32 bits: RAM read data, valid after the RAM's negedge.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCESS and RESP, with all outputs registered.
REQ-016 SHALL sample requests only on posedges where the state is IDLE or RESP; the request fields SHALL be latched on the same edge.
REQ-017 SHALL, from IDLE or RESP with any request sampled, go to ACCESS, pulse the winner's gnt for that cycle, and drive ram_addr, ram_wdata and ram_rw.
REQ-018 SHALL, from IDLE or RESP with no request sampled, go to IDLE.
REQ-019 SHALL always go from ACCESS to RESP; on that edge ram_rdata SHALL be captured into the winner's rdata if the access was a read.
REQ-020 SHALL, in RESP, pulse the winner's done together with err, and SHALL return ram_rw to 0.
REQ-021 SHALL complete a single access as: request sampled at edge E0, gnt in cycle E0..E1, done in cycle E1..E2; back-to-back throughput SHALL be one access per 2 cycles.
REQ-022 SHALL arbitrate round-robin: on simultaneous requests the port not granted most recently wins; a lone requester always wins.
REQ-023 SHALL leave the losing request pending; the loser SHALL keep req and its fields stable until its gnt.
REQ-024 SHALL treat req still high at the edge where the state is RESP as a new request, so a requester wanting one access drops req in the gnt cycle.
REQ-025 SHALL flag an access as an error when addr[1:0]!=0 or addr>MEM_BYTES-4.
REQ-026 SHALL, for an error access, still pass through ACCESS and RESP, force ram_rw=0, and return rdata=0 with err=1.
REQ-027 SHALL never write to the RAM for an error access.
REQ-028 SHALL, for a write, leave the port's rdata unchanged and return err=0.
REQ-029 SHALL never change the non-winning port's rdata.
REQ-030 SHALL drive ram_rw=0 in IDLE, while ram_addr and ram_wdata hold their last values.

Reset
REQ-031 SHALL, when rst_n is low, immediately force: state=IDLE, all gnt/done/err=0, a_rdata=b_rdata=0, ram_rw=0, ram_addr=0, ram_wdata=0.
REQ-032 SHALL, on reset, set last-granted to B, so A wins the first contention.
REQ-033 SHALL, on reset during ACCESS, drop the access with no done; ram_rw SHALL drop before the RAM's negedge if reset arrives within the first half-cycle.

Structure
REQ-034 SHALL take the FSM state enum, MEM_BYTES default and the 32-bit data/addr width constant from the shared package mem_arb_pkg.
REQ-035 SHALL contain exactly one sub-module, rr_pick2: combinational 2-way round-robin pick from req pair plus last-granted bit, producing a one-hot grant.

Verification
REQ-036 SHALL cover: A write 0xDEADBEEF to addr 8, then A read addr 8 -> ram_rw=1 for exactly one cycle, then a_done with a_rdata=0xDEADBEEF, a_err=0.
REQ-037 SHALL cover: A and B request together after reset, both held -> gnt order A, B, A, B across 4 accesses, 2 cycles apart.
REQ-038 SHALL cover: B read addr 6 -> b_done with b_err=1, b_rdata=0, ram_rw stays 0.
REQ-039 SHALL cover: A write addr 64 with MEM_BYTES=64 -> a_err=1 and memory unchanged.
REQ-040 SHALL cover: A write 0x11223344 to addr 60 (boundary) -> accepted, and a readback returns 0x11223344.
REQ-041 SHALL cover: rst_n low in the ACCESS cycle of a write to addr 4 -> no done, all outputs zero, and the next access is granted to A.
